// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the stages downstream of it.
//   DATA_W        : width of the signed ALU result
//   alu_result_t  : signed ALU result type
//   acc_max/min   : saturation limits of a signed accumulator of a given width
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 6;

    typedef logic signed [DATA_W-1:0] alu_result_t;

    // Largest value a signed accumulator of acc_w bits can hold.
    function automatic longint acc_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    // Most negative value a signed accumulator of acc_w bits can hold.
    function automatic longint acc_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// -----------------------------------------------------------------------------
// alu_result_buffer_if
// Result path between the ALU, the result buffer and its consumer.
//   c_en      : ALU result qualifier
//   c         : signed ALU result, meaningful when c_en=1
//   out_valid : buffer head is available
//   out_data  : buffer head, signed
//   out_ready : consumer takes the head this cycle
// The master modport is the environment (ALU side plus consumer side),
// the slave modport is the buffer itself.
// -----------------------------------------------------------------------------
interface alu_result_buffer_if #(
    parameter int DATA_W = alu_pkg::DATA_W
);

    logic                     c_en;
    logic signed [DATA_W-1:0] c;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_ready;

    modport master (
        output c_en,
        output c,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  c_en,
        input  c,
        input  out_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Pointer and occupancy bookkeeping for a power-of-two synchronous FIFO.
//   clk, rst_n : clock and asynchronous active-high reset
//   push_req   : producer offers an entry
//   pop_req    : consumer is ready to take the head
//   wr_ptr     : slot the next accepted entry goes to
//   rd_ptr     : slot holding the head
//   count      : occupancy, full, empty : count==DEPTH / count==0
//   push       : entry is accepted this cycle
//   drop       : entry is refused because the FIFO is full and not draining
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req,
    input  logic             pop_req,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             push,
    output logic             drop
);

    logic pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign pop   = pop_req & ~empty;
    // A full FIFO still takes a new entry when the head leaves in the same cycle.
    assign push  = push_req & (~full | pop);
    assign drop  = push_req & full & ~pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
// Buffers qualified ALU results in a small FIFO for a consumer that may
// stall, keeps a saturating signed running sum of accepted results, and
// reports sticky overflow (result dropped) and saturation flags.
//   clk, rst_n : clock and asynchronous active-high reset
//   bus        : result path (c_en, c, out_valid, out_data, out_ready)
//   clr        : synchronous clear of acc, overflow and acc_sat
//   count      : occupancy, full/empty : FIFO status
//   overflow   : sticky, a result was dropped
//   acc        : signed running sum of accepted results
//   acc_sat    : sticky, acc has clamped at least once
// -----------------------------------------------------------------------------
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int  DATA_W = alu_pkg::DATA_W,
    parameter int  DEPTH  = 8,
    parameter int  ACC_W  = 12,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_result_buffer_if.slave      bus,
    input  logic                    clr,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic signed [ACC_W-1:0] acc,
    output logic                    acc_sat
);

    localparam int PTR_W = $clog2(DEPTH);

    // Limits held one bit wider so the unclamped sum compares without wrapping.
    localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W + 1)'(acc_max(ACC_W));
    localparam logic signed [ACC_W:0] SUM_MIN = (ACC_W + 1)'(acc_min(ACC_W));

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     push;
    logic                     drop;

    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     sat_now;

    sync_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_req (bus.c_en),
        .pop_req  (bus.out_ready),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .push     (push),
        .drop     (drop)
    );

    // Storage is not reset; the head is masked to zero whenever the FIFO is
    // empty, which also covers the moment reset clears the occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.c;
        end
    end

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];

    // A clear in the same cycle as a push restarts the sum from the new result.
    always_comb begin
        acc_base = clr ? '0 : acc;
        sum      = (ACC_W + 1)'(acc_base) + (ACC_W + 1)'(bus.c);
        acc_next = acc_base;
        sat_now  = 1'b0;
        if (push) begin
            if (sum > SUM_MAX) begin
                acc_next = ACC_W'(SUM_MAX);
                sat_now  = 1'b1;
            end else if (sum < SUM_MIN) begin
                acc_next = ACC_W'(SUM_MIN);
                sat_now  = 1'b1;
            end else begin
                acc_next = sum[ACC_W-1:0];
            end
        end
    end

    // Sticky flags: a set event in the clearing cycle still wins.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc      <= '0;
            acc_sat  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            acc      <= acc_next;
            acc_sat  <= (acc_sat & ~clr) | sat_now;
            overflow <= (overflow & ~clr) | drop;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
// Directed bench for alu_result_buffer: a scoreboard queue holds the results
// the buffer should accept, and a small reference model tracks the running
// sum and sticky flags.
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;
    import alu_pkg::*;

    localparam int DEPTH = 8;
    localparam int ACC_W = 12;
    localparam int MAXV  = 2047;
    localparam int MINV  = -2048;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clr;
    logic [3:0]              count;
    logic                    full;
    logic                    empty;
    logic                    overflow;
    logic signed [ACC_W-1:0] acc;
    logic                    acc_sat;

    alu_result_buffer_if bus ();

    alu_result_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ACC_W  (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr      (clr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .acc      (acc),
        .acc_sat  (acc_sat)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    int sb[$];
    int m_acc;
    bit m_sat;
    bit m_ovf;

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic checkState(input string where);
        checkOutput({where, ":count"}, count, sb.size());
        checkOutput({where, ":empty"}, empty, sb.size() == 0);
        checkOutput({where, ":full"}, full, sb.size() == DEPTH);
        checkOutput({where, ":out_valid"}, bus.out_valid, sb.size() != 0);
        checkOutput({where, ":out_data"}, bus.out_data, (sb.size() != 0) ? sb[0] : 0);
        checkOutput({where, ":acc"}, acc, m_acc);
        checkOutput({where, ":acc_sat"}, acc_sat, m_sat);
        checkOutput({where, ":overflow"}, overflow, m_ovf);
    endtask

    task automatic applyStimulus(input string where, input bit en, input int val,
                                 input bit rdy, input bit clr_in);
        bit pop_m;
        bit full_m;
        bit push_m;
        bit drop_m;
        int s;
        bus.c_en      = en;
        bus.c         = DATA_W'(val);
        bus.out_ready = rdy;
        clr           = clr_in;
        pop_m  = rdy && (sb.size() != 0);
        full_m = (sb.size() == DEPTH);
        push_m = en && (!full_m || pop_m);
        drop_m = en && full_m && !pop_m;
        if (pop_m) begin
            checkOutput({where, ":pop_data"}, bus.out_data, sb[0]);
            void'(sb.pop_front());
        end
        if (clr_in) begin
            m_acc = 0;
            m_sat = 1'b0;
            m_ovf = 1'b0;
        end
        if (push_m) begin
            sb.push_back(val);
            s = m_acc + val;
            if (s > MAXV) begin
                m_acc = MAXV;
                m_sat = 1'b1;
            end else if (s < MINV) begin
                m_acc = MINV;
                m_sat = 1'b1;
            end else begin
                m_acc = s;
            end
        end
        if (drop_m) begin
            m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        checkState(where);
    endtask

    initial begin
        bus.c_en      = 1'b0;
        bus.c         = '0;
        bus.out_ready = 1'b0;
        clr           = 1'b0;
        m_acc         = 0;
        m_sat         = 1'b0;
        m_ovf         = 1'b0;
        rst_n         = 1'b0;
        #1 rst_n = 1'b1;
        #1 checkState("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        checkState("post_reset");

        // Single result, then pop.
        applyStimulus("single", 1'b1, 5, 1'b0, 1'b0);
        checkOutput("single:acc5", acc, 5);
        applyStimulus("single_pop", 1'b0, 0, 1'b1, 1'b0);

        // Fill past full with the consumer stalled.
        applyStimulus("clr1", 1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus("fill", 1'b1, i, 1'b0, 1'b0);
        end
        checkOutput("fill:acc36", acc, 36);
        checkOutput("fill:ovf", overflow, 1);
        checkOutput("fill:full", full, 1);
        repeat (8) applyStimulus("drain", 1'b0, 13, 1'b1, 1'b0);
        checkOutput("drain:empty", empty, 1);

        // Push and pop together while full.
        applyStimulus("clr2", 1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus("refill", 1'b1, i, 1'b0, 1'b0);
        end
        applyStimulus("pp_full", 1'b1, -3, 1'b1, 1'b0);
        checkOutput("pp_full:count8", count, 8);
        checkOutput("pp_full:ovf0", overflow, 0);
        repeat (8) applyStimulus("pp_drain", 1'b0, 0, 1'b1, 1'b0);

        // Positive saturation.
        applyStimulus("clr3", 1'b0, 0, 1'b1, 1'b1);
        repeat (67) applyStimulus("possat", 1'b1, 31, 1'b1, 1'b0);
        checkOutput("possat:acc_max", acc, 2047);
        checkOutput("possat:sat", acc_sat, 1);
        applyStimulus("possat_hold", 1'b1, 31, 1'b1, 1'b0);
        checkOutput("possat_hold:acc", acc, 2047);
        applyStimulus("possat_down", 1'b1, -32, 1'b1, 1'b0);
        checkOutput("possat_down:acc", acc, 2015);

        // Negative saturation, overflow, then clear.
        applyStimulus("clr4", 1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 80 && !m_sat; i++) begin
            applyStimulus("negsat", 1'b1, -32, 1'b1, 1'b0);
        end
        checkOutput("negsat:acc_min", acc, -2048);
        checkOutput("negsat:sat", acc_sat, 1);
        repeat (9) applyStimulus("negfill", 1'b1, -32, 1'b0, 1'b0);
        checkOutput("negfill:ovf", overflow, 1);
        applyStimulus("clr5", 1'b0, 9, 1'b0, 1'b1);
        checkOutput("clr5:count", count, 8);
        checkOutput("clr5:acc", acc, 0);
        checkOutput("clr5:sat", acc_sat, 0);
        checkOutput("clr5:ovf", overflow, 0);
        applyStimulus("clr_drop", 1'b1, 10, 1'b0, 1'b1);
        checkOutput("clr_drop:ovf", overflow, 1);
        applyStimulus("clr_push", 1'b1, -7, 1'b1, 1'b1);
        checkOutput("clr_push:acc", acc, -7);
        repeat (4) applyStimulus("to_four", 1'b0, 0, 1'b1, 1'b0);
        checkOutput("to_four:count", count, 4);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b1;
        #1;
        checkOutput("async_rst:count", count, 0);
        checkOutput("async_rst:out_valid", bus.out_valid, 0);
        checkOutput("async_rst:out_data", bus.out_data, 0);
        checkOutput("async_rst:acc", acc, 0);
        checkOutput("async_rst:empty", empty, 1);
        sb.delete();
        m_acc = 0;
        m_sat = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        applyStimulus("after_rst", 1'b1, 7, 1'b0, 1'b0);
        checkOutput("after_rst:data7", bus.out_data, 7);
        checkOutput("after_rst:count1", count, 1);
        applyStimulus("after_rst_pop", 1'b0, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
